divider: RTL and testbench

Sequential 32-bit radix-2 restoring divider for the RV32M DIV, DIVU, REM and REMU instructions. It is the inverse-operation companion to the shift-add multiplier and shares the same start/busy handshake toward the execute-stage control FSM. The execute stage stalls on `busy`. It reads `result` once `done` has pulsed.

---
 rtl/muldiv_pkg.sv | 30 +++
 rtl/div_step.sv | 29 ++
 rtl/divider.sv | 157 +++++++++++++++
 tb/tb_divider.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the RV32M multiply/divide units: operand width,
// funct3[1:0] operation encodings, common FSM state codes and sign helpers.
package muldiv_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 6;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    // 2'b11 is unused by both units and must recover to S_IDLE.
    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    localparam logic [XLEN-1:0] INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL_ONES = {XLEN{1'b1}};

    // |INT_MIN| wraps back to INT_MIN, which is the right unsigned magnitude.
    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v);
        return v[XLEN-1] ? -v : v;
    endfunction

    function automatic logic [XLEN-1:0] neg_if(input logic neg, input logic [XLEN-1:0] v);
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, try subtracting the divisor, and record the quotient bit.
module div_step
    import muldiv_pkg::*;
(
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] trial;

    always_comb begin
        shifted = {rem_i, quo_i[XLEN-1]};
        trial   = shifted - {1'b0, divisor_i};
        // Bit XLEN of the 33-bit difference is the borrow: set means "restore".
        if (!trial[XLEN]) begin
            rem_o = trial[XLEN-1:0];
            quo_o = {quo_i[XLEN-2:0], 1'b1};
        end else begin
            rem_o = shifted[XLEN-1:0];
            quo_o = {quo_i[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/divider.sv
// Sequential radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Handshake: start is sampled only while busy=0; busy stays high until the FSM
// returns to IDLE; done pulses one cycle when result is valid, and result then
// holds until the next accepted start completes or resolves a special case.
module divider
    import muldiv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic [XLEN-1:0] result,
    output logic            busy,
    output logic            done
);

    logic [1:0]       state_q, state_d;
    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  quo_q, quo_d;
    logic [XLEN-1:0]  dvs_q, dvs_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             want_rem_q, want_rem_d;
    logic [XLEN-1:0]  result_q, result_d;

    logic [XLEN-1:0]  step_rem;
    logic [XLEN-1:0]  step_quo;
    logic             is_signed;
    logic             div_zero;
    logic             sgn_ovf;
    logic             special;

    assign is_signed = ~op[0];
    assign div_zero  = (rs2_data == '0);
    assign sgn_ovf   = is_signed && (rs1_data == INT_MIN) && (rs2_data == ALL_ONES);
    assign special   = div_zero | sgn_ovf;

    div_step u_step (
        .rem_i     (rem_q),
        .quo_i     (quo_q),
        .divisor_i (dvs_q),
        .rem_o     (step_rem),
        .quo_o     (step_quo)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = S_IDLE;
        case (state_q)
            S_IDLE: begin
                if (!start) begin
                    state_d = S_IDLE;
                end else if (special) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_RUN:   state_d = (count_q == '0) ? S_DONE : S_RUN;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy   = (state_q != S_IDLE);
        done   = (state_q == S_DONE);
        result = result_q;
    end

    // Datapath next values
    always_comb begin
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
        count_d    = count_q;
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
        want_rem_d = want_rem_q;
        result_d   = result_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (div_zero) begin
                        result_d = op[1] ? rs1_data : ALL_ONES;
                    end else if (sgn_ovf) begin
                        result_d = op[1] ? '0 : INT_MIN;
                    end else begin
                        want_rem_d = op[1];
                        rem_d      = '0;
                        count_d    = CNT_W'(XLEN);
                        if (is_signed) begin
                            quo_d   = abs_val(rs1_data);
                            dvs_d   = abs_val(rs2_data);
                            q_neg_d = rs1_data[XLEN-1] ^ rs2_data[XLEN-1];
                            r_neg_d = rs1_data[XLEN-1];
                        end else begin
                            quo_d   = rs1_data;
                            dvs_d   = rs2_data;
                            q_neg_d = 1'b0;
                            r_neg_d = 1'b0;
                        end
                    end
                end
            end
            S_RUN: begin
                if (count_q != '0) begin
                    rem_d   = step_rem;
                    quo_d   = step_quo;
                    count_d = count_q - 1'b1;
                end else begin
                    // Remainder takes the dividend's sign, quotient the XOR of both.
                    result_d = want_rem_q ? neg_if(r_neg_q, rem_q)
                                          : neg_if(q_neg_q, quo_q);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            count_q    <= '0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            want_rem_q <= 1'b0;
            result_q   <= '0;
        end else begin
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvs_q      <= dvs_d;
            count_q    <= count_d;
            q_neg_q    <= q_neg_d;
            r_neg_q    <= r_neg_d;
            want_rem_q <= want_rem_d;
            result_q   <= result_d;
        end
    end

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for the divider: directed RV32M corner cases plus random
// operations, checked against plain-arithmetic reference results.
module tb_divider;
    import muldiv_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] result;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    divider dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .result   (result),
        .busy     (busy),
        .done     (done)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: RV32M semantics via 64-bit signed arithmetic.
    function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r = 0;
        case (o)
            OP_DIVU: r = (b == 0) ? longint'(32'hFFFF_FFFF) : longint'(a / b);
            OP_REMU: r = (b == 0) ? longint'(a) : longint'(a % b);
            OP_DIV:  r = (b == 0) ? -1 : sa / sb;
            default: r = (b == 0) ? sa : sa % sb;
        endcase
        return r[31:0];
    endfunction

    function automatic bit is_special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        return (b == 0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // Monitor: every done pulse consumes one expected result.
    always @(negedge clk) begin
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 expected no pending operation");
            end else begin
                check("result", result, exp_q.pop_front());
            end
        end
    end

    // Driver: issue one operation, optionally poke a second start or a reset,
    // and check the busy/done timing of the accepted operation.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int poke_at, input int reset_at);
        int  n;
        int  busy_cnt;
        int  done_cnt;
        int  done_at;
        bit  fin;
        bit  spc;
        spc = is_special(o, a, b);
        @(negedge clk);
        op = o; rs1_data = a; rs2_data = b; start = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        start = 1'b0; op = 2'($urandom); rs1_data = $urandom; rs2_data = $urandom;
        n = 0; busy_cnt = 0; done_cnt = 0; done_at = -1; fin = 1'b0;
        while (!fin) begin
            if (n == reset_at) begin
                reset = 1'b1;
                #2;
                check("reset_busy", 32'(busy), 32'd0);
                check("reset_done", 32'(done), 32'd0);
                check("reset_result", result, 32'd0);
                void'(exp_q.pop_back());
                @(negedge clk);
                reset = 1'b0;
                return;
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = n;
            end
            if (!busy) begin
                fin = 1'b1;
            end else if (n >= 100) begin
                checks++;
                errors++;
                $display("FAIL timeout: got busy after %0d cycles expected idle", n);
                fin = 1'b1;
            end else begin
                if (n == poke_at) begin
                    start = 1'b1; op = 2'($urandom); rs1_data = $urandom; rs2_data = $urandom | 32'd1;
                end else begin
                    start = 1'b0;
                end
                n++;
                @(posedge clk);
                #1;
            end
        end
        start = 1'b0;
        check("busy_cycles", 32'(busy_cnt), spc ? 32'd1 : 32'd34);
        check("done_cycles", 32'(done_cnt), 32'd1);
        check("done_latency", 32'(done_at), spc ? 32'd0 : 32'd33);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        reset = 1'b1; start = 1'b0; op = '0; rs1_data = '0; rs2_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_result", result, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op(OP_DIVU, 32'd100, 32'd7, 32'd14, -1, -1);
        run_op(OP_REMU, 32'd100, 32'd7, 32'd2, -1, -1);
        run_op(OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, -1, -1);
        run_op(OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, -1, -1);
        run_op(OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, -1, -1);
        run_op(OP_REM,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, -1, -1);
        run_op(OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, -1, -1);
        run_op(OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, -1, -1);
        run_op(OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, -1, -1);
        run_op(OP_DIV,  32'h8000_0000, 32'd1, 32'h8000_0000, -1, -1);
        run_op(OP_REMU, 32'd1234, 32'hFFFF_FFFF, 32'd1234, -1, -1);
        run_op(OP_DIV,  32'd0, 32'd0, 32'hFFFF_FFFF, -1, -1);

        // Second start while busy must be ignored.
        run_op(OP_DIVU, 32'd1000, 32'd10, 32'd100, 9, -1);
        // Reset mid-operation discards the result; the next op runs cleanly.
        run_op(OP_DIVU, 32'd77, 32'd5, 32'd15, -1, 20);
        run_op(OP_DIVU, 32'd9, 32'd3, 32'd3, -1, -1);

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 9))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF;
                3:       begin ra = 32'h8000_0000; rb = $urandom; end
                4:       rb = $urandom >> $urandom_range(0, 31);
                default: rb = $urandom;
            endcase
            run_op(ro, ra, rb, ref_div(ro, ra, rb), -1, -1);
        end

        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending: got %0d outstanding results expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
